// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// cycle counts, the HI/LO pair payload and the 32x32->64 product helper.
package md_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // HI/LO register pair
  typedef struct packed {
    logic [MD_XLEN-1:0] hi;
    logic [MD_XLEN-1:0] lo;
  } md_pair_t;

  // Full 64-bit product; sign-extending to 64 bits makes the truncated
  // unsigned product equal to the signed product.
  function automatic md_pair_t md_mul(input logic [MD_XLEN-1:0] a,
                                      input logic [MD_XLEN-1:0] b,
                                      input logic               is_signed);
    logic [2*MD_XLEN-1:0] ax;
    logic [2*MD_XLEN-1:0] bx;
    logic [2*MD_XLEN-1:0] p;
    ax = {{MD_XLEN{is_signed & a[MD_XLEN-1]}}, a};
    bx = {{MD_XLEN{is_signed & b[MD_XLEN-1]}}, b};
    p  = ax * bx;
    return '{hi: p[2*MD_XLEN-1:MD_XLEN], lo: p[MD_XLEN-1:0]};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
//   start/op/rs/rt : request, sampled on the rising clock edge
//   busy           : operation in progress
//   hi/lo          : committed HI and LO registers
interface md_unit_if;

  logic                            start;
  logic [md_pkg::MD_OP_W-1:0]      op;
  logic [md_pkg::MD_XLEN-1:0]      rs;
  logic [md_pkg::MD_XLEN-1:0]      rt;
  logic                            busy;
  logic [md_pkg::MD_XLEN-1:0]      hi;
  logic [md_pkg::MD_XLEN-1:0]      lo;

  modport master (output start, op, rs, rt, input busy, hi, lo);
  modport slave  (input start, op, rs, rt, output busy, hi, lo);

endinterface

// File: rtl/md_div.sv
// Combinational 32-bit divider, signed or unsigned.
//   dividend, divisor : operands
//   is_signed         : 1 = signed (quotient toward zero, remainder takes
//                       dividend sign), 0 = unsigned
//   quot_c, rem_c     : quotient and remainder
//   div0_c            : divisor is zero (quotient/remainder meaningless)
module md_div
  import md_pkg::*;
(
  input  logic [MD_XLEN-1:0] dividend,
  input  logic [MD_XLEN-1:0] divisor,
  input  logic               is_signed,
  output logic [MD_XLEN-1:0] quot_c,
  output logic [MD_XLEN-1:0] rem_c,
  output logic               div0_c
);

  logic               neg_a;
  logic               neg_b;
  logic [MD_XLEN-1:0] mag_a;
  logic [MD_XLEN-1:0] mag_b;
  logic [MD_XLEN-1:0] mag_b_safe;
  logic [MD_XLEN-1:0] q_u;
  logic [MD_XLEN-1:0] r_u;

  // Divide magnitudes unsigned, then restore signs; this keeps
  // 0x80000000 / -1 well defined (wraps to 0x80000000, remainder 0).
  always_comb begin
    neg_a      = is_signed & dividend[MD_XLEN-1];
    neg_b      = is_signed & divisor[MD_XLEN-1];
    mag_a      = neg_a ? (MD_XLEN'(0) - dividend) : dividend;
    mag_b      = neg_b ? (MD_XLEN'(0) - divisor) : divisor;
    div0_c     = (divisor == '0);
    mag_b_safe = div0_c ? MD_XLEN'(1) : mag_b;
    q_u        = mag_a / mag_b_safe;
    r_u        = mag_a % mag_b_safe;
    quot_c     = (neg_a ^ neg_b) ? (MD_XLEN'(0) - q_u) : q_u;
    rem_c      = neg_a ? (MD_XLEN'(0) - r_u) : r_u;
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : md_unit_if slave (start/op/rs/rt in, busy/hi/lo out)
// Results are latched into pending registers at acceptance and committed
// to hi/lo only on the edge ending the last busy cycle.
// Build option: define MD_UNIT_DIV_EN to implement DIV/DIVU; otherwise
// they behave as no-ops and no divider is built.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               commit_q, commit_d;
  md_pair_t           pend_q, pend_d;
  logic [MD_XLEN-1:0] hi_q, hi_d;
  logic [MD_XLEN-1:0] lo_q, lo_d;
  md_pair_t           prod;

  assign prod = md_mul(bus.rs, bus.rt, ~bus.op[0]);

`ifdef MD_UNIT_DIV_EN
  logic [MD_XLEN-1:0] div_quot;
  logic [MD_XLEN-1:0] div_rem;
  logic               div_zero;

  md_div u_div (
    .dividend  (bus.rs),
    .divisor   (bus.rt),
    .is_signed (~bus.op[0]),
    .quot_c    (div_quot),
    .rem_c     (div_rem),
    .div0_c    (div_zero)
  );
`endif

  // Next-state: accept only in IDLE, count down in RUN, commit at the end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    pend_d   = pend_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              pend_d   = prod;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = ST_RUN;
            end
`ifdef MD_UNIT_DIV_EN
            MD_DIV, MD_DIVU: begin
              pend_d   = '{hi: div_rem, lo: div_quot};
              // divide by zero still occupies the unit but never commits
              commit_d = ~div_zero;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = ST_RUN;
            end
`endif
            MD_MTHI: hi_d = bus.rs;
            MD_MTLO: lo_d = bus.rs;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          commit_d = 1'b0;
          if (commit_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      pend_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
      pend_q   <= pend_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table of single operations with
// hand-computed busy length and HI/LO, then sequences for requests while
// busy and reset in the middle of an operation.
module tb_md_unit;
  import md_pkg::*;

  logic clk;
  logic reset;

  md_unit_if bus();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;
  int unsigned n;
  bit          flag;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one request and follows it to completion.
  task automatic run_vec(input vec_t v);
    int unsigned cnt;
    bit          mid_ok;
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.rs    = v.rs;
    bus.rt    = v.rt;
    @(negedge clk);
    bus.start = 1'b0;
    cnt       = 0;
    mid_ok    = 1'b1;
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin
      cnt++;
      if (bus.hi !== cur_hi || bus.lo !== cur_lo) mid_ok = 1'b0;
      @(negedge clk);
    end
    check_n({v.name, " busy_cycles"}, cnt, v.cyc);
    if (v.cyc != 0) check_n({v.name, " hidden_mid_op"}, 32'(mid_ok), 1);
    check32({v.name, " hi"}, bus.hi, v.hi);
    check32({v.name, " lo"}, bus.lo, v.lo);
    cur_hi = v.hi;
    cur_lo = v.lo;
  endtask

  initial begin
    vecs.push_back('{"mult_neg1x2",  MD_MULT,  32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"multu_ffx2",   MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{"mthi",         MD_MTHI,  32'h12345678, 32'h00000000, 0, 32'h12345678, 32'hFFFFFFFE});
    vecs.push_back('{"mtlo",         MD_MTLO,  32'hCAFEF00D, 32'h11111111, 0, 32'h12345678, 32'hCAFEF00D});
    vecs.push_back('{"nop6",         3'd6,     32'h00000001, 32'h00000002, 0, 32'h12345678, 32'hCAFEF00D});
    vecs.push_back('{"nop7",         3'd7,     32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h12345678, 32'hCAFEF00D});
    vecs.push_back('{"mult_min_sq",  MD_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000});
    vecs.push_back('{"multu_max_sq", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_7xm3",    MD_MULT,  32'h00000007, 32'hFFFFFFFD, 5, 32'hFFFFFFFF, 32'hFFFFFFEB});
`ifdef MD_UNIT_DIV_EN
    vecs.push_back('{"div_m7by2",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_7by0",    MD_DIVU,  32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_ovf",      MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000});
    vecs.push_back('{"divu_big",     MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF});
    vecs.push_back('{"div_7bym2",    MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
`else
    vecs.push_back('{"div_off",      MD_DIV,   32'h0000000A, 32'h00000002, 0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"divu_off",     MD_DIVU,  32'h00000007, 32'h00000003, 0, 32'hFFFFFFFF, 32'hFFFFFFEB});
`endif

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.rs    = '0;
    bus.rt    = '0;
    repeat (3) @(negedge clk);
    check32("reset busy", 32'(bus.busy), 32'h0);
    check32("reset hi", bus.hi, 32'h0);
    check32("reset lo", bus.lo, 32'h0);

    // first vector issued so the first edge after release accepts it
    reset = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);

    // MULT with further requests in busy cycles 2, 3 (MTLO) and 5
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    bus.rs    = 32'd3;
    bus.rt    = 32'd4;
    @(negedge clk);
    n = 0;
    for (int c = 1; c <= 5; c++) begin
      if (bus.busy === 1'b1) n++;
      bus.start = (c == 2 || c == 3 || c == 5);
      bus.op    = (c == 3) ? MD_MTLO : MD_MULT;
      bus.rs    = (c == 3) ? 32'hDEAD0000 : 32'd5;
      bus.rt    = 32'd5;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_n("busy_ignore busy_cycles", n, 5);
    check32("busy_ignore busy_after", 32'(bus.busy), 32'h0);
    check32("busy_ignore hi", bus.hi, 32'h0);
    check32("busy_ignore lo", bus.lo, 32'h0000000C);
    flag = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) flag = 1'b0;
    end
    check32("busy_ignore stays_idle", 32'(flag), 32'h1);
    check32("busy_ignore lo_stable", bus.lo, 32'h0000000C);

    // reset during the third busy cycle of a long operation
    bus.start = 1'b1;
`ifdef MD_UNIT_DIV_EN
    bus.op    = MD_DIV;
`else
    bus.op    = MD_MULT;
`endif
    bus.rs    = 32'd100;
    bus.rt    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check32("midreset busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check32("midreset busy", 32'(bus.busy), 32'h0);
    check32("midreset hi", bus.hi, 32'h0);
    check32("midreset lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    flag = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) flag = 1'b0;
    end
    check32("midreset no_commit", 32'(flag), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
